// File: rtl/shreg_serializer.sv
// Parallel-load, per-lane serializer: a width*depth word is emitted one slot per
// accepted q cycle, with ready/valid on both sides and zero-bubble reload.

module shreg_lane #(
   parameter int depth = 130
) (
   input  logic             clk,
   input  logic             load,
   input  logic             shift,
   input  logic [depth-1:0] din,
   output logic             dout
);
   logic [depth-1:0] sr;

   // Data-only store; its contents are never visible while no word is held.
   always_ff @(posedge clk) begin
      if (load)
         sr <= din;
      else if (shift)
         sr <= sr >> 1;
   end

   assign dout = sr[0];
endmodule

module shreg_serializer #(
   parameter int width = 1,
   parameter int depth = 130
) (
   input  logic                   clk,
   input  logic                   r,
   input  logic                   load_valid,
   input  logic [width*depth-1:0] load_data,
   output logic                   load_ready,
   output logic [width-1:0]       q,
   output logic                   q_valid,
   input  logic                   q_ready,
   output logic                   q_last
);
   localparam int CW = (depth > 1) ? $clog2(depth) : 1;
   localparam logic [CW-1:0] LAST = CW'(depth - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            accept, advance, at_last;
   logic [width-1:0] lane_q;

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A load in SHIFT is only possible on the consumed last slot, so accept
   // takes priority over the plain advance/return-to-idle path.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      q_valid    = (state == SHIFT);
      at_last    = (cnt == LAST);
      q_last     = q_valid & at_last;
      advance    = q_valid & q_ready;
      load_ready = ~q_valid | (q_ready & q_last);
      accept     = load_valid & load_ready;
      if (accept) begin
         state_nxt = SHIFT;
         cnt_nxt   = '0;
      end else if (advance) begin
         if (at_last)
            state_nxt = IDLE;
         else
            cnt_nxt = cnt + 1'b1;
      end
   end

   for (genvar w = 0; w < width; w++) begin : g_lane
      logic [depth-1:0] lane_word;
      for (genvar d = 0; d < depth; d++) begin : g_slot
         assign lane_word[d] = load_data[d*width + w];
      end
      shreg_lane #(.depth(depth)) u_lane (
         .clk   (clk),
         .load  (accept),
         .shift (advance),
         .din   (lane_word),
         .dout  (lane_q[w])
      );
   end

   assign q = q_valid ? lane_q : '0;
endmodule

// File: tb/tb_shreg_serializer.sv
// Bench for shreg_serializer: three configurations checked every cycle against a
// slot-index model, plus directed literal expectations.

module tb_shreg_serializer;
   logic clk = 1'b0;
   logic r;
   always #5 clk = ~clk;

   // a: width=1 depth=4, b: width=2 depth=3, c: width=4 depth=1
   logic       a_lv, a_qr, a_rdy, a_q, a_vld, a_last;
   logic [3:0] a_ld;
   logic       b_lv, b_qr, b_rdy, b_vld, b_last;
   logic [5:0] b_ld;
   logic [1:0] b_q;
   logic       c_lv, c_qr, c_rdy, c_vld, c_last;
   logic [3:0] c_ld, c_q;

   shreg_serializer #(.width(1), .depth(4)) u_a (
      .clk(clk), .r(r), .load_valid(a_lv), .load_data(a_ld), .load_ready(a_rdy),
      .q(a_q), .q_valid(a_vld), .q_ready(a_qr), .q_last(a_last));
   shreg_serializer #(.width(2), .depth(3)) u_b (
      .clk(clk), .r(r), .load_valid(b_lv), .load_data(b_ld), .load_ready(b_rdy),
      .q(b_q), .q_valid(b_vld), .q_ready(b_qr), .q_last(b_last));
   shreg_serializer #(.width(4), .depth(1)) u_c (
      .clk(clk), .r(r), .load_valid(c_lv), .load_data(c_ld), .load_ready(c_rdy),
      .q(c_q), .q_valid(c_vld), .q_ready(c_qr), .q_last(c_last));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: the held word plus the index of the slot currently on q.
   int          mw[3] = '{1, 2, 4};
   int          md[3] = '{4, 3, 1};
   logic [15:0] m_word[3];
   int          m_pos[3];
   bit          m_held[3];

   always @(negedge clk) begin : compare
      logic [15:0] ld[3], oq[3], mask, eq;
      logic        lv[3], qr[3], ov[3], ol[3], ordy[3];
      bit          held, last, erdy;
      ld[0] = {12'd0, a_ld}; lv[0] = a_lv; qr[0] = a_qr;
      ld[1] = {10'd0, b_ld}; lv[1] = b_lv; qr[1] = b_qr;
      ld[2] = {12'd0, c_ld}; lv[2] = c_lv; qr[2] = c_qr;
      oq[0] = {15'd0, a_q}; ov[0] = a_vld; ol[0] = a_last; ordy[0] = a_rdy;
      oq[1] = {14'd0, b_q}; ov[1] = b_vld; ol[1] = b_last; ordy[1] = b_rdy;
      oq[2] = {12'd0, c_q}; ov[2] = c_vld; ol[2] = c_last; ordy[2] = c_rdy;
      for (int k = 0; k < 3; k++) begin
         held = m_held[k] && (r === 1'b1);
         last = held && (m_pos[k] == md[k] - 1);
         mask = (16'd1 << mw[k]) - 16'd1;
         eq   = held ? ((m_word[k] >> (m_pos[k] * mw[k])) & mask) : 16'd0;
         erdy = !held || (qr[k] && last);
         chk($sformatf("model%0d.q_valid", k), {15'd0, ov[k]}, {15'd0, held});
         chk($sformatf("model%0d.q", k), oq[k], eq);
         chk($sformatf("model%0d.q_last", k), {15'd0, ol[k]}, {15'd0, last});
         chk($sformatf("model%0d.load_ready", k), {15'd0, ordy[k]}, {15'd0, erdy});
         if (r !== 1'b1)
            m_held[k] = 1'b0;
         else if (lv[k] && erdy) begin
            m_word[k] = ld[k];
            m_pos[k]  = 0;
            m_held[k] = 1'b1;
         end else if (held && qr[k]) begin
            if (last) m_held[k] = 1'b0;
            else      m_pos[k]  = m_pos[k] + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  s028;
      logic [7:0]  s031;
      logic [5:0]  s029;
      r = 1'b0;
      a_lv = 0; a_ld = '0; a_qr = 1;
      b_lv = 0; b_ld = '0; b_qr = 1;
      c_lv = 0; c_ld = '0; c_qr = 1;

      @(negedge clk);
      chk("rst.q_valid", {15'd0, a_vld}, 16'd0);
      chk("rst.q", {15'd0, a_q}, 16'd0);
      chk("rst.q_last", {15'd0, a_last}, 16'd0);
      chk("rst.load_ready", {15'd0, a_rdy}, 16'd1);
      chk("rst.c_q", {12'd0, c_q}, 16'd0);

      // first edge after release accepts the word; slots 1,1,0,1
      tick();
      a_lv = 1; a_ld = 4'b1011;
      #2 r = 1'b1;
      @(negedge clk);
      chk("r028.pre_valid", {15'd0, a_vld}, 16'd0);
      tick();
      a_lv = 0; a_ld = '0;
      s028 = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("r028.q", {15'd0, a_q}, {15'd0, s028[i]});
         chk("r028.q_last", {15'd0, a_last}, (i == 3) ? 16'd1 : 16'd0);
         tick();
      end
      @(negedge clk);
      chk("r028.done_valid", {15'd0, a_vld}, 16'd0);

      // backpressure on slot 1 for three cycles
      a_lv = 1; a_ld = 4'b0110;
      tick();
      a_lv = 0;
      @(negedge clk);
      chk("r030.slot0", {15'd0, a_q}, 16'd0);
      tick();
      a_qr = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("r030.hold_q", {15'd0, a_q}, 16'd1);
         chk("r030.hold_last", {15'd0, a_last}, 16'd0);
         tick();
      end
      a_qr = 1;
      @(negedge clk);
      chk("r030.slot1", {15'd0, a_q}, 16'd1);
      tick();
      @(negedge clk);
      chk("r030.slot2", {15'd0, a_q}, 16'd1);
      tick();
      @(negedge clk);
      chk("r030.slot3", {15'd0, a_q}, 16'd0);
      chk("r030.slot3_last", {15'd0, a_last}, 16'd1);
      tick();
      @(negedge clk);
      chk("r030.done_valid", {15'd0, a_vld}, 16'd0);

      // back-to-back 0xA then 0x5, no bubble
      a_lv = 1; a_ld = 4'hA;
      s031 = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 0) a_ld = 4'h5;
         if (i == 4) a_lv = 0;
         @(negedge clk);
         chk("r031.q_valid", {15'd0, a_vld}, 16'd1);
         chk("r031.q", {15'd0, a_q}, {15'd0, s031[i]});
         chk("r031.q_last", {15'd0, a_last}, (i == 3 || i == 7) ? 16'd1 : 16'd0);
      end
      tick();
      @(negedge clk);
      chk("r031.done_valid", {15'd0, a_vld}, 16'd0);

      // reset pulse during slot 2
      a_lv = 1; a_ld = 4'hF;
      tick();
      a_lv = 0;
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("r032.slot2_valid", {15'd0, a_vld}, 16'd1);
      #1 r = 1'b0;
      #1;
      chk("r032.q_valid", {15'd0, a_vld}, 16'd0);
      chk("r032.q", {15'd0, a_q}, 16'd0);
      chk("r032.q_last", {15'd0, a_last}, 16'd0);
      chk("r032.load_ready", {15'd0, a_rdy}, 16'd1);
      @(negedge clk);
      #1 r = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("r032.after_valid", {15'd0, a_vld}, 16'd0);
      end

      // width=2 depth=3
      tick();
      b_lv = 1; b_ld = 6'b10_01_11;
      tick();
      b_lv = 0;
      s029 = 6'b10_01_11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("r029.q", {14'd0, b_q}, {14'd0, s029[2*i +: 2]});
         chk("r029.q_last", {15'd0, b_last}, (i == 2) ? 16'd1 : 16'd0);
         tick();
      end
      @(negedge clk);
      chk("r029.done_valid", {15'd0, b_vld}, 16'd0);

      // depth=1, load held: every cycle is a valid last slot
      tick();
      c_lv = 1; c_ld = 4'hC;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("r033.q", {12'd0, c_q}, 16'h000C);
         chk("r033.valid_last", {14'd0, c_vld, c_last}, 16'd3);
         tick();
      end
      c_lv = 0;
      tick();
      @(negedge clk);
      chk("r033.done_valid", {15'd0, c_vld}, 16'd0);

      // mixed traffic with random valid/ready, checked by the model
      for (int i = 0; i < 60; i++) begin
         tick();
         a_lv = 1'($urandom); a_ld = 4'($urandom); a_qr = 1'($urandom);
         b_lv = 1'($urandom); b_ld = 6'($urandom); b_qr = 1'($urandom);
         c_lv = 1'($urandom); c_ld = 4'($urandom); c_qr = 1'($urandom);
      end
      tick();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
